trap_ctrl: RTL and testbench

Parametrised machine-mode trap controller for the pipelined RISC-V core. It is the successor to the single-cause exception unit. It owns the trap CSRs (mstatus.MIE/MPIE, mie, mip, mtvec, mepc, mcause, mtval) and arbitrates synchronous exceptions against NUM_IRQ level-sensitive interrupt lines. On trap entry and on mret it flushes all pipeline registers and redirects IF. It adds vectored mtvec mode, mtval capture and a single-cycle CSR commit.

---
 rtl/trap_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap controller.
// Owns mstatus(MIE/MPIE), mie, mip, mtvec, mepc, mcause, mtval; arbitrates a
// synchronous exception at WB, mret, and NUM_IRQ level interrupts; flushes the
// pipeline and redirects IF on trap entry and on mret.
// Ports:
//   clk, rst                     clock, async active-high reset
//   csr_op/csr_addr/csr_wdata    CSR access (00 none, 01 rw, 10 rs, 11 rc)
//   csr_rdata                    combinational read of csr_addr
//   exc_valid/exc_code/exc_tval  synchronous exception at WB
//   epc_cur/epc_next             PC of WB / next surviving PC
//   irq                          level interrupt requests
//   mret                         mret at WB
//   pc_redirect/redirect_valid   IF redirect
//   flush/regwrite_cancel        pipeline flush / WB write suppression
//   busy                         controller is in ENTER or RET

// One interrupt line: pending when requested and enabled in mie.
module trap_irq_lane (
  input  logic irq,
  input  logic en,
  output logic pend
);
  assign pend = irq & en;
endmodule

module trap_ctrl #(
  parameter int              XLEN           = 32,
  parameter int              NUM_IRQ        = 4,
  parameter int              IRQ_BASE_CAUSE = 16,
  parameter logic [XLEN-1:0] MTVEC_RESET    = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  input  logic               exc_valid,
  input  logic [4:0]         exc_code,
  input  logic [XLEN-1:0]    exc_tval,
  input  logic [XLEN-1:0]    epc_cur,
  input  logic [XLEN-1:0]    epc_next,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               mret,
  output logic [XLEN-1:0]    pc_redirect,
  output logic               redirect_valid,
  output logic               flush,
  output logic               regwrite_cancel,
  output logic               busy
);

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;
  localparam logic [11:0] A_MIP     = 12'h344;

  localparam logic [XLEN-1:0] MSTATUS_MASK = XLEN'(8'h88);
  localparam logic [XLEN-1:0] MIE_MASK =
    {{(XLEN-NUM_IRQ){1'b0}}, {NUM_IRQ{1'b1}}} << IRQ_BASE_CAUSE;
  localparam logic [XLEN-1:0] MTVEC_MASK = ~XLEN'(2);
  localparam logic [XLEN-1:0] MEPC_MASK  = ~XLEN'(3);

  typedef enum logic [1:0] {S_IDLE, S_ENTER, S_RET} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   mstatus_q, mie_q, mtvec_q, mepc_q, mcause_q, mtval_q;
  logic              flush_q;
  logic [XLEN-1:0]   mip;
  logic [NUM_IRQ-1:0] pend;
  logic [4:0]        irq_idx;
  logic              idle, take_exc, take_ret, take_irq, take_any;
  logic [XLEN-1:0]   wr_val;
  logic              wr_req, wr_en;
  logic [XLEN-1:0]   trap_base, trap_tgt;

  function automatic logic [XLEN-1:0] mstat(input logic mie_b, input logic mpie_b);
    return XLEN'({mpie_b, 3'b000, mie_b, 3'b000});
  endfunction

  assign mip = XLEN'(irq) << IRQ_BASE_CAUSE;

  trap_irq_lane u_lane [NUM_IRQ-1:0] (
    .irq  (irq),
    .en   (mie_q[IRQ_BASE_CAUSE +: NUM_IRQ]),
    .pend (pend)
  );

  // Lowest pending index wins: scan downward so the last hit is the lowest.
  always_comb begin
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (pend[i]) irq_idx = 5'(i);
  end

  assign idle     = (state_q == S_IDLE);
  assign take_exc = idle & exc_valid;
  assign take_ret = idle & ~exc_valid & mret;
  assign take_irq = idle & ~exc_valid & ~mret & mstatus_q[3] & (|pend);
  assign take_any = take_exc | take_ret | take_irq;

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      A_MSTATUS: csr_rdata = mstatus_q;
      A_MIE:     csr_rdata = mie_q;
      A_MIP:     csr_rdata = mip;
      A_MTVEC:   csr_rdata = mtvec_q;
      A_MEPC:    csr_rdata = mepc_q;
      A_MCAUSE:  csr_rdata = mcause_q;
      A_MTVAL:   csr_rdata = mtval_q;
      default:   csr_rdata = '0;
    endcase
  end

  // rs/rc with a zero operand are pure reads and must not write.
  always_comb begin
    wr_val = csr_rdata;
    wr_req = 1'b0;
    case (csr_op)
      2'b01: begin wr_val = csr_wdata;              wr_req = 1'b1;        end
      2'b10: begin wr_val = csr_rdata | csr_wdata;  wr_req = |csr_wdata;  end
      2'b11: begin wr_val = csr_rdata & ~csr_wdata; wr_req = |csr_wdata;  end
      default: ;
    endcase
  end

  // A trap or mret on the same edge wins over the CSR instruction.
  assign wr_en = wr_req & idle & ~take_any;

  // Vectored mode offsets only interrupts; exceptions always go to base.
  always_comb begin
    trap_base = {mtvec_q[XLEN-1:2], 2'b00};
    trap_tgt  = trap_base;
    if (mtvec_q[1:0] == 2'b01 && mcause_q[XLEN-1])
      trap_tgt = trap_base + XLEN'({mcause_q[XLEN-2:0], 2'b00});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    redirect_valid = 1'b0;
    pc_redirect    = '0;
    case (state_q)
      S_IDLE: begin
        if (take_exc | take_irq) state_d = S_ENTER;
        else if (take_ret)       state_d = S_RET;
      end
      S_ENTER: begin
        state_d        = S_IDLE;
        redirect_valid = 1'b1;
        pc_redirect    = trap_tgt;
      end
      S_RET: begin
        state_d        = S_IDLE;
        redirect_valid = 1'b1;
        pc_redirect    = mepc_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);

  // flush is its own register (not decoded from state) so it is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flush_q <= 1'b0;
    else     flush_q <= take_any;
  end

  assign flush           = flush_q;
  assign regwrite_cancel = flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_q <= '0;
      mie_q     <= '0;
      mtvec_q   <= MTVEC_RESET & MTVEC_MASK;
      mepc_q    <= '0;
      mcause_q  <= '0;
      mtval_q   <= '0;
    end else if (take_exc) begin
      mepc_q    <= epc_cur & MEPC_MASK;
      mcause_q  <= XLEN'(exc_code);
      mtval_q   <= exc_tval;
      mstatus_q <= mstat(1'b0, mstatus_q[3]);
    end else if (take_ret) begin
      mstatus_q <= mstat(mstatus_q[7], 1'b1);
    end else if (take_irq) begin
      mepc_q    <= epc_next & MEPC_MASK;
      mcause_q  <= {1'b1, (XLEN-1)'(IRQ_BASE_CAUSE) + (XLEN-1)'(irq_idx)};
      mtval_q   <= '0;
      mstatus_q <= mstat(1'b0, mstatus_q[3]);
    end else if (wr_en) begin
      case (csr_addr)
        A_MSTATUS: mstatus_q <= wr_val & MSTATUS_MASK;
        A_MIE:     mie_q     <= wr_val & MIE_MASK;
        A_MTVEC:   mtvec_q   <= wr_val & MTVEC_MASK;
        A_MEPC:    mepc_q    <= wr_val & MEPC_MASK;
        A_MCAUSE:  mcause_q  <= wr_val;
        A_MTVAL:   mtval_q   <= wr_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;
  localparam int          XLEN      = 32;
  localparam int          NUM_IRQ   = 4;
  localparam int          BASE      = 16;
  localparam logic [31:0] MTVEC_RST = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0]  csr_op = '0;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0, csr_rdata;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_code = '0;
  logic [31:0] exc_tval = '0, epc_cur = '0, epc_next = '0;
  logic [NUM_IRQ-1:0] irq = '0;
  logic        mret = 1'b0;
  logic [31:0] pc_redirect;
  logic        redirect_valid, flush, regwrite_cancel, busy;

  trap_ctrl #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ), .IRQ_BASE_CAUSE(BASE), .MTVEC_RESET(MTVEC_RST)) dut (
    .clk(clk), .rst(rst), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .exc_valid(exc_valid), .exc_code(exc_code), .exc_tval(exc_tval),
    .epc_cur(epc_cur), .epc_next(epc_next), .irq(irq), .mret(mret),
    .pc_redirect(pc_redirect), .redirect_valid(redirect_valid), .flush(flush),
    .regwrite_cancel(regwrite_cancel), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // ---- behavioural model: CSR values plus a "redirect window" flag ----
  bit          m_mie_b, m_mpie_b, m_win;
  logic [31:0] m_mie, m_mtvec, m_mepc, m_mcause, m_mtval, e_pc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_mie_b = 0; m_mpie_b = 0; m_win = 0; e_pc = 0;
    m_mie = 0; m_mtvec = MTVEC_RST & ~32'h2; m_mepc = 0; m_mcause = 0; m_mtval = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return (m_mpie_b ? 32'h80 : 32'h0) | (m_mie_b ? 32'h8 : 32'h0);
      12'h304: return m_mie;
      12'h344: return 32'(irq) << BASE;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_target();
    logic [31:0] b = m_mtvec & ~32'h3;
    if ((m_mtvec & 32'h3) == 32'h1 && m_mcause[31]) return b + 4 * (m_mcause & 32'h7FFF_FFFF);
    return b;
  endfunction

  // Applies what the edge just seen must do, given the inputs held across it.
  task automatic model_step();
    int idx;
    logic [31:0] old, nv;
    bit do_wr;
    if (rst) begin model_reset(); return; end
    if (m_win) begin m_win = 0; e_pc = 0; return; end
    idx = -1;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (irq[i] && m_mie[BASE + i]) idx = i;
    if (exc_valid) begin
      m_mepc = epc_cur & ~32'h3; m_mcause = 32'(exc_code); m_mtval = exc_tval;
      m_mpie_b = m_mie_b; m_mie_b = 0; m_win = 1; e_pc = model_target();
    end else if (mret) begin
      m_mie_b = m_mpie_b; m_mpie_b = 1; m_win = 1; e_pc = m_mepc;
    end else if (m_mie_b && idx >= 0) begin
      m_mepc = epc_next & ~32'h3; m_mcause = 32'h8000_0000 | 32'(BASE + idx); m_mtval = 0;
      m_mpie_b = m_mie_b; m_mie_b = 0; m_win = 1; e_pc = model_target();
    end else if (csr_op != 2'b00) begin
      old = model_read(csr_addr);
      nv = (csr_op == 2'b01) ? csr_wdata : (csr_op == 2'b10) ? (old | csr_wdata) : (old & ~csr_wdata);
      do_wr = (csr_op == 2'b01) || (csr_wdata != 0);
      if (do_wr) case (csr_addr)
        12'h300: begin m_mie_b = nv[3]; m_mpie_b = nv[7]; end
        12'h304: m_mie = nv & (32'hF << BASE);
        12'h305: m_mtvec = nv & ~32'h2;
        12'h341: m_mepc = nv & ~32'h3;
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
        default: ;
      endcase
    end
  endtask

  // Single compare process, mid-cycle.
  always @(negedge clk) begin
    chk("flush", 32'(flush), 32'(m_win));
    chk("regwrite_cancel", 32'(regwrite_cancel), 32'(m_win));
    chk("redirect_valid", 32'(redirect_valid), 32'(m_win));
    chk("busy", 32'(busy), 32'(m_win));
    chk("pc_redirect", pc_redirect, m_win ? e_pc : 32'h0);
    chk("csr_rdata", csr_rdata, model_read(csr_addr));
  end

  // ---- stimulus helpers ----
  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_op = op; csr_addr = a; csr_wdata = d;
    tick();
    csr_op = 2'b00;
  endtask

  task automatic rd(input string nm, input logic [11:0] a, input logic [31:0] exp);
    csr_op = 2'b00; csr_addr = a;
    #1;
    chk(nm, csr_rdata, exp);
  endtask

  logic [11:0] addr_tab [8] = '{12'h300, 12'h304, 12'h344, 12'h305, 12'h341, 12'h342, 12'h343, 12'h7FF};
  logic [4:0]  code_tab [4] = '{5'd2, 5'd5, 5'd7, 5'd11};

  initial begin
    model_reset();
    #1 rst = 1'b1;
    tick(); tick();
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_pc", pc_redirect, 32'h0);
    rd("rst_mtvec", 12'h305, MTVEC_RST);
    rst = 1'b0;

    // Exception in direct mode.
    csr(2'b01, 12'h305, 32'h100);
    exc_valid = 1; exc_code = 5'd2; epc_cur = 32'h40; exc_tval = 32'h1234_5678;
    tick();
    exc_valid = 0;
    chk("exc_flush", 32'(flush), 32'h1);
    chk("exc_redir", 32'(redirect_valid), 32'h1);
    chk("exc_pc", pc_redirect, 32'h100);
    rd("exc_mepc", 12'h341, 32'h40);
    rd("exc_mcause", 12'h342, 32'h2);
    rd("exc_mtval", 12'h343, 32'h1234_5678);
    rd("exc_mstatus", 12'h300, 32'h0);
    tick();

    // Vectored interrupt, lowest enabled index wins.
    csr(2'b01, 12'h305, 32'h201);
    csr(2'b01, 12'h304, 32'h6_0000);
    csr(2'b01, 12'h300, 32'h8);
    irq = 4'b0110; epc_next = 32'h80;
    tick();
    irq = 4'b0000;
    chk("irq_pc", pc_redirect, 32'h244);
    rd("irq_mcause", 12'h342, 32'h8000_0011);
    rd("irq_mepc", 12'h341, 32'h80);
    rd("irq_mstatus", 12'h300, 32'h80);
    tick();

    // Exception beats a simultaneous interrupt; the interrupt follows mret.
    csr(2'b10, 12'h304, 32'h1_0000);
    csr(2'b10, 12'h300, 32'h8);
    exc_valid = 1; exc_code = 5'd11; epc_cur = 32'h300; exc_tval = 32'hDEAD; irq = 4'b0001; epc_next = 32'h500;
    tick();
    exc_valid = 0;
    chk("pri_pc", pc_redirect, 32'h200);
    rd("pri_mcause", 12'h342, 32'd11);
    rd("pri_mepc", 12'h341, 32'h300);
    rd("pri_mtval", 12'h343, 32'hDEAD);
    tick();
    tick();
    chk("pri_masked", 32'(busy), 32'h0);
    mret = 1;
    tick();
    mret = 0;
    chk("ret_pc", pc_redirect, 32'h300);
    rd("ret_mstatus", 12'h300, 32'h88);
    tick();
    tick();
    chk("late_irq_pc", pc_redirect, 32'h240);
    rd("late_irq_mcause", 12'h342, 32'h8000_0010);
    rd("late_irq_mepc", 12'h341, 32'h500);
    irq = 4'b0000;
    tick();

    // Plain mret.
    csr(2'b01, 12'h341, 32'h40);
    csr(2'b01, 12'h300, 32'h80);
    mret = 1;
    tick();
    mret = 0;
    chk("mret_valid", 32'(redirect_valid), 32'h1);
    chk("mret_pc", pc_redirect, 32'h40);
    rd("mret_mstatus", 12'h300, 32'h88);
    tick();

    // CSR op corner cases on mie.
    csr(2'b10, 12'h304, 32'h0);
    rd("mie_rs0", 12'h304, 32'h7_0000);
    csr(2'b11, 12'h304, 32'h1_0000);
    rd("mie_rc", 12'h304, 32'h6_0000);
    csr(2'b01, 12'h304, 32'h7FF);
    rd("mie_rw_masked", 12'h304, 32'h0);
    exc_valid = 1; exc_code = 5'd5; epc_cur = 32'h60;
    csr(2'b01, 12'h304, 32'h4_0000);
    exc_valid = 0;
    rd("mie_dropped", 12'h304, 32'h0);
    rd("drop_mcause", 12'h342, 32'h5);
    tick();

    // Reset during ENTER.
    exc_valid = 1;
    tick();
    exc_valid = 0;
    chk("enter_busy", 32'(busy), 32'h1);
    rst = 1; model_reset();
    #1;
    chk("rst_enter_redir", 32'(redirect_valid), 32'h0);
    chk("rst_enter_flush", 32'(flush), 32'h0);
    chk("rst_enter_pc", pc_redirect, 32'h0);
    rd("rst_enter_mtvec", 12'h305, MTVEC_RST);
    tick();
    rst = 0;
    csr(2'b01, 12'h304, 32'hF_0000);
    irq = 4'b1111;
    tick(); tick(); tick();
    chk("rst_irq_ignored", 32'(busy), 32'h0);
    irq = 0;

    // Randomized phase against the model.
    for (int c = 0; c < 3000; c++) begin
      if (rst) rst = 0;
      else if ($urandom_range(0, 299) == 0) begin rst = 1; model_reset(); end
      csr_op    = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      csr_addr  = ($urandom_range(0, 7) == 0) ? 12'($urandom) : addr_tab[$urandom_range(0, 7)];
      case ($urandom_range(0, 4))
        0: csr_wdata = 32'h0;
        1: csr_wdata = 32'h88;
        2: csr_wdata = 32'hF_0000;
        3: csr_wdata = 32'h201;
        default: csr_wdata = $urandom;
      endcase
      exc_valid = ($urandom_range(0, 19) == 0);
      exc_code  = code_tab[$urandom_range(0, 3)];
      exc_tval  = $urandom;
      epc_cur   = $urandom;
      epc_next  = $urandom;
      mret      = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 3) == 0) irq = NUM_IRQ'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
